// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the receive-side symbol deserializer.
package deser_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_SYM_W  = 2;
  localparam int DEF_SYMS   = DEF_WORD_W / DEF_SYM_W;
  localparam int CNT_W      = $clog2(DEF_SYMS);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/deser_out_fifo.sv
// Two-entry valid/ready output buffer with registered head; a push into a full
// buffer is accepted only when the head is popped on the same edge.
module deser_out_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   occupancy
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;
  logic         accept;

  assign pop    = m_ready && (occ_q != 2'd0);
  assign accept = push && ((occ_q != 2'd2) || pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({pop, accept})
      2'b11: begin
        // Occupancy is unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      2'b10: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) begin
          head_d = push_data;
        end else begin
          tail_d = push_data;
        end
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign m_data    = head_q;
  assign m_valid   = (occ_q != 2'd0);
  assign full      = (occ_q == 2'd2);
  assign occupancy = occ_q;

endmodule

// File: rtl/deserializer.sv
// Rebuilds WORD_W words from an MSB-first SYM_W symbol stream into a 2-entry buffer.
// Optional error counters are enabled with the DESER_ERR_CNT_EN macro.
module deserializer
  import deser_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int SYM_W  = DEF_SYM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SYM_W-1:0]  s_in,
  input  logic              s_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_err,
  output logic              overflow
`ifdef DESER_ERR_CNT_EN
  ,
  output logic [7:0]        frame_err_cnt,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int SYMS    = WORD_W / SYM_W;
  localparam int COUNT_W = (SYMS > 1) ? $clog2(SYMS) : 1;

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic                frame_err_q, frame_err_d;
  logic                overflow_q, overflow_d;
  logic                push;
  logic [WORD_W-1:0]   push_data;
  logic                fifo_full;
  logic [1:0]          fifo_occ;
  logic                word_drop;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_data   = {shift_q[WORD_W-SYM_W-1:0], s_in};
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          shift_d = push_data;
          count_d = COUNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (s_valid) begin
          shift_d = push_data;
          if (count_q == COUNT_W'(SYMS - 1)) begin
            push    = 1'b1;
            count_d = '0;
            state_d = IDLE;
          end else begin
            count_d = count_q + COUNT_W'(1);
          end
        end else begin
          frame_err_d = 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Upstream cannot be stalled, so a full buffer without a same-edge pop loses the word.
  assign word_drop  = push && fifo_full && !m_ready;
  assign overflow_d = overflow_q || word_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  deser_out_fifo #(
    .W (WORD_W)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .occupancy (fifo_occ)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (fifo_full == (fifo_occ == 2'd2));
    end
  end

  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

`ifdef DESER_ERR_CNT_EN
  logic [7:0] frame_err_cnt_q, frame_err_cnt_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_err_cnt_d = frame_err_cnt_q;
    drop_cnt_d      = drop_cnt_q;
    if (frame_err_d && (frame_err_cnt_q != 8'hFF)) begin
      frame_err_cnt_d = frame_err_cnt_q + 8'd1;
    end
    if (word_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_cnt_q <= 8'd0;
      drop_cnt_q      <= 8'd0;
    end else begin
      frame_err_cnt_q <= frame_err_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign frame_err_cnt = frame_err_cnt_q;
  assign drop_cnt      = drop_cnt_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus a randomized run,
// all compared cycle by cycle against a queue-based reference model.
module tb_deserializer;

  localparam int WORD_W = 16;
  localparam int SYM_W  = 2;
  localparam int SYMS   = WORD_W / SYM_W;

  logic              clk;
  logic              rst_n;
  logic [SYM_W-1:0]  s_in;
  logic              s_valid;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              frame_err;
  logic              overflow;
`ifdef DESER_ERR_CNT_EN
  logic [7:0]        frame_err_cnt;
  logic [7:0]        drop_cnt;
`endif

  deserializer #(
    .WORD_W (WORD_W),
    .SYM_W  (SYM_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
`ifdef DESER_ERR_CNT_EN
    ,
    .frame_err_cnt (frame_err_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector; data is masked when the buffer is empty.
  wire [WORD_W+2:0] dut_obs = {m_valid, (m_valid ? m_data : {WORD_W{1'b0}}), frame_err, overflow};

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [SYM_W-1:0]  part_q[$];
  logic [WORD_W-1:0] mbuf[$];
  logic              exp_ferr;
  logic              exp_ovf;
  int                mfe_cnt;
  int                mdrop_cnt;

  // Observation of the current scenario
  logic [WORD_W-1:0] got_q[$];
  int                got_cyc[$];
  int                ferr_seen;
  int                valid_cycles;
  int                cyc = 0;

  // Stimulus tables
  logic              stim_v[$];
  logic [SYM_W-1:0]  stim_s[$];
  logic              stim_r[$];

  function automatic logic [WORD_W+2:0] model_vec();
    logic [WORD_W-1:0] head;
    head = '0;
    if (mbuf.size() != 0) head = mbuf[0];
    return {(mbuf.size() != 0), head, exp_ferr, exp_ovf};
  endfunction

  task automatic model_reset();
    part_q.delete();
    mbuf.delete();
    exp_ferr  = 1'b0;
    exp_ovf   = 1'b0;
    mfe_cnt   = 0;
    mdrop_cnt = 0;
  endtask

  task automatic clear_stim();
    stim_v.delete();
    stim_s.delete();
    stim_r.delete();
    got_q.delete();
    got_cyc.delete();
    ferr_seen    = 0;
    valid_cycles = 0;
  endtask

  task automatic add(input logic v, input logic [SYM_W-1:0] s, input logic r);
    stim_v.push_back(v);
    stim_s.push_back(s);
    stim_r.push_back(r);
  endtask

  task automatic add_word(input logic [WORD_W-1:0] w, input logic r);
    for (int i = 0; i < SYMS; i++) add(1'b1, w[WORD_W-1-SYM_W*i -: SYM_W], r);
  endtask

  task automatic add_idle(input int n, input logic r);
    for (int i = 0; i < n; i++) add(1'b0, '0, r);
  endtask

  // Drives one cycle, records handshakes, advances the model and the DUT by one edge.
  task automatic step(input logic v, input logic [SYM_W-1:0] s, input logic r);
    logic              pop;
    logic              done;
    logic              next_ferr;
    logic [WORD_W-1:0] w;
    s_valid = v;
    s_in    = s;
    m_ready = r;
    #1;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_cyc.push_back(cyc);
    end
    pop       = r && (mbuf.size() != 0);
    done      = 1'b0;
    next_ferr = 1'b0;
    w         = '0;
    if (v) begin
      part_q.push_back(s);
      if (part_q.size() == SYMS) begin
        foreach (part_q[i]) w = {w[WORD_W-SYM_W-1:0], part_q[i]};
        done = 1'b1;
        part_q.delete();
      end
    end else if (part_q.size() != 0) begin
      part_q.delete();
      next_ferr = 1'b1;
    end
    if (pop) void'(mbuf.pop_front());
    if (done) begin
      if (mbuf.size() < 2) begin
        mbuf.push_back(w);
      end else begin
        exp_ovf = 1'b1;
        if (mdrop_cnt < 255) mdrop_cnt++;
      end
    end
    exp_ferr = next_ferr;
    if (next_ferr && mfe_cnt < 255) mfe_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_err) ferr_seen++;
    if (m_valid) valid_cycles++;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_in    = '0;
    m_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_obs !== '0) $display("FAIL reset_outputs: got %h expected 0", dut_obs);
    else passes++;
`ifdef DESER_ERR_CNT_EN
    checks++;
    if ({frame_err_cnt, drop_cnt} !== 16'h0)
      $display("FAIL reset_counters: got %h/%h expected 0/0", frame_err_cnt, drop_cnt);
    else passes++;
`endif
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_single();
    clear_stim();
    add_word(16'hA5C3, 1'b1);
    add_idle(3, 1'b1);
    for (int i = 0; i < stim_v.size(); i++) begin
      step(stim_v[i], stim_s[i], stim_r[i]);
      checks++;
      if (dut_obs !== model_vec()) $display("FAIL single c%0d: got %h expected %h", i, dut_obs, model_vec());
      else passes++;
      if (i == SYMS - 1) begin
        checks++;
        if (!(m_valid === 1'b1 && m_data === 16'hA5C3))
          $display("FAIL single_latency: got v=%b d=%h expected v=1 d=a5c3", m_valid, m_data);
        else passes++;
      end
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'hA5C3 || valid_cycles != 1 || ferr_seen != 0)
      $display("FAIL single_summary: got n=%0d vcyc=%0d ferr=%0d expected n=1 vcyc=1 ferr=0",
               got_q.size(), valid_cycles, ferr_seen);
    else passes++;
    $display("test_single: words=%0d", got_q.size());
  endtask

  task automatic test_back_to_back();
    clear_stim();
    add_word(16'h1234, 1'b1);
    add_word(16'hFFFF, 1'b1);
    add_idle(3, 1'b1);
    for (int i = 0; i < stim_v.size(); i++) begin
      step(stim_v[i], stim_s[i], stim_r[i]);
      checks++;
      if (dut_obs !== model_vec()) $display("FAIL b2b c%0d: got %h expected %h", i, dut_obs, model_vec());
      else passes++;
    end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 16'h1234 || got_q[1] !== 16'hFFFF)
      $display("FAIL b2b_order: got n=%0d expected 1234,ffff", got_q.size());
    else passes++;
    checks++;
    if (got_cyc.size() != 2 || (got_cyc[1] - got_cyc[0]) != SYMS)
      $display("FAIL b2b_spacing: got %0d transfers expected 2 spaced %0d", got_cyc.size(), SYMS);
    else passes++;
    $display("test_back_to_back: words=%0d", got_q.size());
  endtask

  task automatic test_truncation();
    clear_stim();
    for (int i = 0; i < 5; i++) add(1'b1, SYM_W'($urandom_range(0, 3)), 1'b1);
    add_idle(1, 1'b1);
    add_word(16'h0F0F, 1'b1);
    add_idle(3, 1'b1);
    for (int i = 0; i < stim_v.size(); i++) begin
      step(stim_v[i], stim_s[i], stim_r[i]);
      checks++;
      if (dut_obs !== model_vec()) $display("FAIL trunc c%0d: got %h expected %h", i, dut_obs, model_vec());
      else passes++;
    end
    checks++;
    if (ferr_seen != 1 || got_q.size() != 1 || got_q[0] !== 16'h0F0F || overflow !== 1'b0)
      $display("FAIL trunc_summary: got ferr=%0d n=%0d ovf=%b expected ferr=1 n=1 (0f0f) ovf=0",
               ferr_seen, got_q.size(), overflow);
    else passes++;
    $display("test_truncation: frame_err pulses=%0d", ferr_seen);
  endtask

  task automatic test_full_pop();
    logic [WORD_W-1:0] w3;
    clear_stim();
    w3 = 16'h3333;
    add_word(16'h1111, 1'b0);
    add_word(16'h2222, 1'b0);
    for (int i = 0; i < SYMS; i++) add(1'b1, w3[WORD_W-1-SYM_W*i -: SYM_W], (i == SYMS - 1));
    add_idle(4, 1'b1);
    for (int i = 0; i < stim_v.size(); i++) begin
      step(stim_v[i], stim_s[i], stim_r[i]);
      checks++;
      if (dut_obs !== model_vec()) $display("FAIL fullpop c%0d: got %h expected %h", i, dut_obs, model_vec());
      else passes++;
    end
    checks++;
    if (got_q.size() != 3 || got_q[0] !== 16'h1111 || got_q[1] !== 16'h2222 ||
        got_q[2] !== 16'h3333 || overflow !== 1'b0)
      $display("FAIL fullpop_summary: got n=%0d ovf=%b expected n=3 ovf=0", got_q.size(), overflow);
    else passes++;
    $display("test_full_pop: words=%0d", got_q.size());
  endtask

  task automatic test_backpressure();
    clear_stim();
    add_word(16'h0001, 1'b0);
    add_word(16'h0002, 1'b0);
    add_word(16'h0003, 1'b0);
    add_idle(3, 1'b0);
    add_idle(4, 1'b1);
    for (int i = 0; i < stim_v.size(); i++) begin
      step(stim_v[i], stim_s[i], stim_r[i]);
      checks++;
      if (dut_obs !== model_vec()) $display("FAIL bp c%0d: got %h expected %h", i, dut_obs, model_vec());
      else passes++;
    end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 16'h0001 || got_q[1] !== 16'h0002 ||
        overflow !== 1'b1 || m_valid !== 1'b0)
      $display("FAIL bp_summary: got n=%0d ovf=%b v=%b expected n=2 ovf=1 v=0",
               got_q.size(), overflow, m_valid);
    else passes++;
    $display("test_backpressure: words=%0d overflow=%b", got_q.size(), overflow);
  endtask

  task automatic test_reset_mid_word();
    clear_stim();
    for (int i = 0; i < 4; i++) add(1'b1, SYM_W'($urandom_range(0, 3)), 1'b1);
    for (int i = 0; i < stim_v.size(); i++) begin
      step(stim_v[i], stim_s[i], stim_r[i]);
      checks++;
      if (dut_obs !== model_vec()) $display("FAIL rstmid pre c%0d: got %h expected %h", i, dut_obs, model_vec());
      else passes++;
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_obs !== '0) $display("FAIL rstmid_async: got %h expected 0", dut_obs);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (dut_obs !== '0) $display("FAIL rstmid_held: got %h expected 0", dut_obs);
    else passes++;
`ifdef DESER_ERR_CNT_EN
    checks++;
    if ({frame_err_cnt, drop_cnt} !== 16'h0)
      $display("FAIL rstmid_counters: got %h/%h expected 0/0", frame_err_cnt, drop_cnt);
    else passes++;
`endif
    rst_n = 1'b1;
    clear_stim();
    add_word(16'hBEEF, 1'b1);
    add_idle(3, 1'b1);
    for (int i = 0; i < stim_v.size(); i++) begin
      step(stim_v[i], stim_s[i], stim_r[i]);
      checks++;
      if (dut_obs !== model_vec()) $display("FAIL rstmid post c%0d: got %h expected %h", i, dut_obs, model_vec());
      else passes++;
    end
    checks++;
    if (ferr_seen != 0 || got_q.size() != 1 || got_q[0] !== 16'hBEEF)
      $display("FAIL rstmid_summary: got ferr=%0d n=%0d expected ferr=0 n=1 (beef)", ferr_seen, got_q.size());
    else passes++;
    $display("test_reset_mid_word: words=%0d", got_q.size());
  endtask

  task automatic test_random();
    int errs_before;
    clear_stim();
    errs_before = checks - passes;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), SYM_W'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      checks++;
      if (dut_obs !== model_vec()) $display("FAIL random c%0d: got %h expected %h", i, dut_obs, model_vec());
      else passes++;
`ifdef DESER_ERR_CNT_EN
      checks++;
      if (frame_err_cnt !== 8'(mfe_cnt) || drop_cnt !== 8'(mdrop_cnt))
        $display("FAIL random_counters c%0d: got %0d/%0d expected %0d/%0d",
                 i, frame_err_cnt, drop_cnt, mfe_cnt, mdrop_cnt);
      else passes++;
`endif
    end
    $display("test_random: words=%0d frame_errs=%0d new_failures=%0d",
             got_q.size(), ferr_seen, (checks - passes) - errs_before);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_truncation();
    test_full_pop();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Downstream stage of the 2-bit serializer. Samples its symbol stream (s_out/data_valid) MSB-first and rebuilds 16-bit words.
- Completed words go to the consumer through a 2-entry output buffer with a valid/ready handshake.
- Truncated frames and buffer overflows are detected and flagged.
- Sits on the receive side of the link, feeding the downstream packet logic.

Parameters:
- WORD_W, 16: reassembled word width. Must be a multiple of SYM_W.
- SYM_W, 2: symbol width per cycle.
- SYMS (localparam), WORD_W/SYM_W = 8: symbols per word.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_in  in  SYM_W  serial symbol. The first symbol received is the MSBs of the word.
- s_valid  in  1  symbol qualifier. Symbol is sampled on every clk edge where s_valid=1.
- m_data  out  WORD_W  head-of-buffer word.
- m_valid  out  1  buffer non-empty.
- m_ready  in  1  consumer accept. Transfer occurs when m_valid & m_ready.
- frame_err  out  1  one-cycle pulse when a partial word is discarded.
- overflow  out  1  sticky. Set when a completed word is dropped because the buffer is full. Cleared only by reset.

Behaviour:
- Reset (async assert, sync release) clears the shift register, the symbol count, the FSM and the buffer. Output reset values: m_data=0, m_valid=0, frame_err=0, overflow=0. Reset mid-word discards the partial word with no error.
- FSM has two states, IDLE and COLLECT.
  - IDLE, s_valid=1: shift s_in in, count=1, go to COLLECT.
  - COLLECT, s_valid=1: shift_reg <= {shift_reg[WORD_W-SYM_W-1:0], s_in}; count++.
  - COLLECT, s_valid=1, count==SYMS-1: the word completes on this edge. Push {shift_reg, s_in} to the buffer, count=0, go to IDLE. A symbol valid on the very next cycle starts a new word with no gap needed.
  - COLLECT, s_valid=0: truncated frame. Discard the partial word, pulse frame_err for one cycle (registered, the cycle after the drop), count=0, go to IDLE.
- Latency: last symbol sampled at edge N. Word visible on m_data with m_valid=1 after edge N, in cycle N+1, when the buffer was empty.
- Buffer is a 2-entry FIFO with registered outputs. m_data holds the head entry and stays stable while m_valid=1 and m_ready=0.
  - A push is accepted if occupancy<2, or if occupancy==2 and a pop occurs in the same cycle.
  - Otherwise the completed word is dropped and overflow is set. The collection path never stalls, because the upstream stage has no backpressure.
  - Simultaneous push and pop at occupancy 1 keeps occupancy 1; the new word becomes head the next cycle.
  - A pop when empty is ignored.
- m_ready is ignored while m_valid=0. m_data is don't-care when m_valid=0 but must not be X after reset.

Optional Feature:
- Macro: DESER_ERR_CNT_EN.
- When defined: adds outputs frame_err_cnt[7:0] and drop_cnt[7:0].
  - Both are saturating counters (stop at 255) and reset to 0.
  - frame_err_cnt increments on each frame_err pulse; drop_cnt on each overflow drop.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package deser_pkg holds:
  - default WORD_W/SYM_W;
  - SYMS as a derived constant;
  - count width $clog2(SYMS);
  - FSM state encoding (IDLE=1'b0, COLLECT=1'b1).
- Sub-module deser_out_fifo: 2-entry valid/ready FIFO with push, push_data, full, pop via m_ready, occupancy. It is reusable by other receive-side stages.

Test Plan:
- Single word:
  - Stimulus: 8 consecutive valid symbols 2,2,1,1,3,0,0,3 with m_ready=1.
  - Response: m_data=16'hA5C3 with m_valid=1 for exactly one cycle, in the cycle after the 8th symbol. frame_err=0.
- Back-to-back:
  - Stimulus: 16 continuous valid symbols encoding 16'h1234 then 16'hFFFF, with m_ready=1.
  - Response: two transfers, 16'h1234 then 16'hFFFF, spaced 8 cycles apart.
- Truncation:
  - Stimulus: 5 valid symbols, s_valid low for 1 cycle, then 8 symbols encoding 16'h0F0F.
  - Response: one frame_err pulse, only 16'h0F0F delivered, overflow=0.
- Backpressure/overflow:
  - Stimulus: m_ready=0, three words 16'h0001, 16'h0002, 16'h0003.
  - Response: m_valid=1 with m_data=16'h0001 held stable; the third word is dropped and overflow=1. After m_ready=1, 16'h0001 then 16'h0002 drain, then m_valid=0.
- Full with simultaneous pop:
  - Stimulus: buffer holds 2 words, third word completes in the same cycle as m_ready=1.
  - Response: no drop, overflow stays 0, all three words delivered in order.
- Reset mid-word:
  - Stimulus: rst_n low after 4 symbols, release, then send 16'hBEEF.
  - Response: all outputs 0 during reset, no frame_err, 16'hBEEF delivered.
  - With DESER_ERR_CNT_EN: both counters read 0.
